uart_rx: RTL and testbench

//  8N1 UART receiver for the board UART_RXD pin; the receive-side counterpart of the UART_TXD path.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_rx_fifo.sv | 76 +++++++
 rtl/uart_rx.sv | 189 ++++++++++++++++++
 tb/tb_uart_rx.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART receive path.
//   rx_state_t : receiver FSM states
//   calc_div   : system clocks per oversample tick, rounded to nearest
//   width_of   : counter width for a 0..n-1 range (never below 1 bit)
//   majority3  : 2-of-3 vote used by the bit sampler
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int BIT_IDX_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    // Round-to-nearest keeps the tick rate error below half a clock per tick.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// First-word-fall-through FIFO for received bytes.
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset, empties the FIFO
//   push       in   write push_data (dropped when full unless pop is also taken)
//   push_data  in   WIDTH-bit write data
//   pop        in   remove the head entry (ignored when empty)
//   head       out  current head entry, 0 while empty
//   full       out  DEPTH entries held
//   empty      out  no entries held
// A push into a full FIFO succeeds when a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = width_of(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers wrap naturally because DEPTH is a power of 2.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; stale contents are never visible because the
    // head output is forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver: synchroniser, oversample tick divider, 3-point majority
// bit sampler, frame FSM and a small FWFT receive FIFO.
//   CLOCK_50     in   system clock, rising edge
//   RESET        in   synchronous active-high reset
//   uart_rxd     in   asynchronous serial input, idle high
//   rx_data      out  FIFO head byte, valid while rx_valid=1 (0 otherwise)
//   rx_valid     out  FIFO non-empty
//   rx_ready     in   consumer takes the head when rx_valid & rx_ready
//   frame_err    out  1-cycle pulse: stop bit sampled low
//   overrun_err  out  1-cycle pulse: good byte dropped because FIFO full
//   rx_busy      out  receiver FSM not idle
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       rx_busy
);

    localparam int DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int DIV_W = width_of(DIV);
    localparam int S_W   = width_of(OVERSAMPLE);

    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [S_W-1:0]       S_LAST   = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0]       S_SAMP_A = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0]       S_SAMP_B = S_W'(OVERSAMPLE / 2);
    localparam logic [S_W-1:0]       S_DECIDE = S_W'(OVERSAMPLE / 2 + 1);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(DATA_BITS - 1);

    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("uart_rx: OVERSAMPLE must be even and >= 8");
    end

    // ---------------------------------------------------------------- sync
    logic rxd_meta;
    logic rxd_s;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_s    <= rxd_meta;
        end
    end

    // ---------------------------------------------------------- tick / phase
    rx_state_t         state;
    logic [DIV_W-1:0]  div_cnt;
    logic [S_W-1:0]    s_cnt;
    logic              rx_run;
    logic              start_det;
    logic              tick;
    logic              decide;
    logic              bit_val;
    logic              samp_a;
    logic              samp_b;

    assign rx_run    = (state == RX_START) || (state == RX_DATA) || (state == RX_STOP);
    assign start_det = (state == RX_IDLE) && !rxd_s;
    assign tick      = rx_run && (div_cnt == DIV_LAST);
    assign decide    = tick && (s_cnt == S_DECIDE);
    // The third vote is the live line value on the decide tick.
    assign bit_val   = majority3(samp_a, samp_b, rxd_s);

    // Clearing on the start edge aligns every bit's sample points to it.
    always_ff @(posedge CLOCK_50) begin
        if (RESET || start_det) begin
            div_cnt <= '0;
            s_cnt   <= '0;
        end else if (rx_run) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                s_cnt   <= (s_cnt == S_LAST) ? '0 : s_cnt + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------ FSM
    logic [DATA_BITS-1:0] shreg;
    logic [BIT_IDX_W-1:0] bit_idx;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state     <= RX_IDLE;
            bit_idx   <= '0;
            shreg     <= '0;
            samp_a    <= 1'b1;
            samp_b    <= 1'b1;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (tick && (s_cnt == S_SAMP_A)) samp_a <= rxd_s;
            if (tick && (s_cnt == S_SAMP_B)) samp_b <= rxd_s;

            case (state)
                RX_IDLE: begin
                    if (!rxd_s) state <= RX_START;
                end
                RX_START: begin
                    if (decide) begin
                        if (bit_val) begin
                            state <= RX_IDLE;     // glitch, not a real start bit
                        end else begin
                            state   <= RX_DATA;
                            bit_idx <= '0;
                        end
                    end
                end
                RX_DATA: begin
                    if (decide) begin
                        shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (decide) begin
                        // Leaving mid-stop lets an immediately following start edge be seen.
                        if (bit_val) begin
                            state <= RX_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= RX_BREAK;
                        end
                    end
                end
                RX_BREAK: begin
                    if (rxd_s) state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    assign rx_busy = (state != RX_IDLE);

    // ----------------------------------------------------------------- FIFO
    logic fifo_push;
    logic fifo_pop;
    logic fifo_full;
    logic fifo_empty;

    // Push on the decide cycle itself so rx_valid rises on the next cycle.
    assign fifo_push = (state == RX_STOP) && decide && bit_val;
    assign fifo_pop  = rx_valid && rx_ready;
    assign rx_valid  = !fifo_empty;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk       (CLOCK_50),
        .rst       (RESET),
        .push      (fifo_push),
        .push_data (shreg),
        .pop       (fifo_pop),
        .head      (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= fifo_push && fifo_full && !fifo_pop;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Scoreboard bench for uart_rx: every good byte sent is queued as expected and
// compared when the consumer side pops it. Error pulses are counted per cycle.
// Runs at 230400 baud so the whole sequence stays short.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 230_400;
    localparam int OS     = 16;
    localparam int DIV    = (CLK_HZ + (BAUD * OS) / 2) / (BAUD * OS);
    localparam int BIT    = DIV * OS;
    localparam int NO_GLITCH = -1;

    logic       CLOCK_50 = 1'b0;
    logic       RESET    = 1'b1;
    logic       uart_rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun_err;
    logic       rx_busy;

    uart_rx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS),
        .FIFO_DEPTH (4)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .RESET       (RESET),
        .uart_rxd    (uart_rxd),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .rx_busy     (rx_busy)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_pops  = 0;
    int         n_ferr  = 0;
    int         n_oerr  = 0;
    int         cyc     = 0;
    int         lat_stop = 0;
    logic [7:0] exp_q[$];

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Consumer-side monitor: pops are compared against the scoreboard.
    always @(negedge CLOCK_50) begin
        if (!RESET) begin
            if (frame_err)   n_ferr++;
            if (overrun_err) n_oerr++;
            if (rx_valid && rx_ready) begin
                n_pops++;
                if (exp_q.size() == 0) check("pop_unexpected", {24'd0, rx_data}, 32'h100);
                else                   check("pop_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    // Start bit, 8 data bits LSB first, stop bit. Optional 1-clock inversion in
    // the middle of one data bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_val, input int glitch_bit);
        for (int b = 0; b < 10; b++) begin
            logic v;
            v = (b == 0) ? 1'b0 : (b == 9) ? stop_val : d[b-1];
            uart_rxd = v;
            if (b >= 1 && b <= 8 && (b - 1) == glitch_bit) begin
                tick_n(BIT / 2);
                uart_rxd = ~v;
                tick_n(1);
                uart_rxd = v;
                tick_n(BIT - BIT / 2 - 1);
            end else begin
                tick_n(BIT);
            end
        end
    endtask

    task automatic drain(input string tag, input int n_exp);
        int p0;
        int k;
        p0 = n_pops;
        rx_ready = 1'b1;
        k = 0;
        @(negedge CLOCK_50);
        while (rx_valid && k < 20) begin
            @(negedge CLOCK_50);
            k++;
        end
        @(posedge CLOCK_50);
        #1;
        rx_ready = 1'b0;
        check({tag, "_pops"}, n_pops - p0, n_exp);
        check({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #(90_000 * 20);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         f0;
        int         o0;
        int         t0;
        logic [7:0] d6;

        // ---------------- reset
        tick_n(4);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_busy", rx_busy, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_oerr", overrun_err, 0);
        RESET = 1'b0;
        tick_n(BIT);
        check("idle_busy", rx_busy, 0);

        // ---------------- T1: single byte, push latency, pop
        exp_q.push_back(8'hA5);
        t0 = cyc;
        fork
            send_frame(8'hA5, 1'b1, NO_GLITCH);
            begin : t1_meas
                int   k;
                logic pv;
                k = 0;
                while (!rx_busy && k < 100) begin
                    @(negedge CLOCK_50);
                    k++;
                end
                check("t1_busy_rise", rx_busy, 1);
                pv = rx_valid;
                k = 0;
                while (rx_busy && k < 12 * BIT) begin
                    pv = rx_valid;
                    @(negedge CLOCK_50);
                    k++;
                end
                lat_stop = cyc - t0;
                check("t1_busy_fall", rx_busy, 0);
                check("t1_valid_before", pv, 0);
                check("t1_valid_after", rx_valid, 1);
                check("t1_in_stop_bit", (lat_stop > 9 * BIT + BIT / 4) && (lat_stop < 10 * BIT), 1);
            end
        join
        check("t1_head", rx_data, 8'hA5);
        rx_ready = 1'b1;
        tick_n(1);
        rx_ready = 1'b0;
        @(negedge CLOCK_50);
        check("t1_valid_popped", rx_valid, 0);
        check("t1_sb_empty", exp_q.size(), 0);
        tick_n(BIT);

        // ---------------- T2: back-to-back, FIFO holds order
        f0 = n_ferr;
        o0 = n_oerr;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        send_frame(8'h00, 1'b1, NO_GLITCH);
        send_frame(8'hFF, 1'b1, NO_GLITCH);
        send_frame(8'h55, 1'b1, NO_GLITCH);
        tick_n(BIT);
        check("t2_valid", rx_valid, 1);
        check("t2_head", rx_data, 8'h00);
        check("t2_no_ferr", n_ferr - f0, 0);
        check("t2_no_oerr", n_oerr - o0, 0);
        drain("t2", 3);

        // ---------------- T3: overrun, then full push+pop
        f0 = n_ferr;
        o0 = n_oerr;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h10 + 8'(i));
        for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b1, NO_GLITCH);
        tick_n(BIT);
        check("t3_overrun_once", n_oerr - o0, 1);
        check("t3_head_first", rx_data, 8'h10);
        check("t3_valid", rx_valid, 1);
        check("t3_no_ferr", n_ferr - f0, 0);

        exp_q.push_back(8'hC3);
        t0 = cyc;
        fork
            send_frame(8'hC3, 1'b1, NO_GLITCH);
            begin
                // One-cycle pop aligned to the push cycle of this frame.
                while (cyc < t0 + lat_stop - 1) begin
                    @(posedge CLOCK_50);
                    #1;
                end
                rx_ready = 1'b1;
                tick_n(1);
                rx_ready = 1'b0;
            end
        join
        tick_n(4);
        check("t3_pushpop_no_oerr", n_oerr - o0, 1);
        check("t3_pushpop_head", rx_data, 8'h11);
        drain("t3", 4);

        // ---------------- T4: framing error, break, recovery
        f0 = n_ferr;
        o0 = n_oerr;
        send_frame(8'h3C, 1'b0, NO_GLITCH);
        tick_n(2 * BIT);
        check("t4_ferr_once", n_ferr - f0, 1);
        check("t4_in_break", rx_busy, 1);
        check("t4_nothing_pushed", rx_valid, 0);
        uart_rxd = 1'b1;
        tick_n(8);
        check("t4_break_exit", rx_busy, 0);
        tick_n(BIT);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, NO_GLITCH);
        check("t4_ferr_still_once", n_ferr - f0, 1);
        drain("t4", 1);

        // ---------------- T5: idle glitch, glitch inside a data bit
        f0 = n_ferr;
        o0 = n_oerr;
        uart_rxd = 1'b0;
        tick_n(2 * DIV);
        check("t5_start_seen", rx_busy, 1);
        tick_n(2 * DIV);
        uart_rxd = 1'b1;
        tick_n(2 * BIT);
        check("t5_false_start_idle", rx_busy, 0);
        check("t5_false_start_nopush", rx_valid, 0);
        check("t5_no_errors", (n_ferr - f0) + (n_oerr - o0), 0);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 3);
        drain("t5", 1);

        // ---------------- T6: reset mid-frame
        d6 = 8'h99;
        f0 = n_ferr;
        uart_rxd = 1'b0;
        tick_n(BIT);
        for (int i = 0; i < 4; i++) begin
            uart_rxd = d6[i];
            tick_n(BIT);
        end
        uart_rxd = d6[4];
        tick_n(BIT / 2);
        check("t6_busy_before_reset", rx_busy, 1);
        RESET = 1'b1;
        tick_n(1);
        RESET = 1'b0;
        @(negedge CLOCK_50);
        check("t6_rst_valid", rx_valid, 0);
        check("t6_rst_data", rx_data, 0);
        check("t6_rst_busy", rx_busy, 0);
        check("t6_rst_ferr", frame_err, 0);
        check("t6_rst_oerr", overrun_err, 0);
        uart_rxd = 1'b1;
        tick_n(2 * BIT);
        check("t6_aborted_nopush", rx_valid, 0);
        check("t6_aborted_noferr", n_ferr - f0, 0);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, NO_GLITCH);
        drain("t6", 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
